combat_arbiter: RTL and testbench
=================================

// Module: combat_arbiter
// PURPOSE
//  Parametrised hit/health/round controller for the VGA fighting game; replaces ad-hoc health logic in the top.
//  Takes per-player hit requests (sprite-overlap & kick), applies damage, runs frame-based invincibility, detects KO/draw.
//  Sits between sprite/collision logic and the health-bar drawbox + rgb mux; all state on clk, timing on frame_tick.
// PARAMETERS
//  NUM_PLAYERS   2    number of fighters (>=2)
//  HEALTH_W      11   width of each health value
//  MAX_HEALTH    300  health loaded at round start (must fit HEALTH_W)
//  DAMAGE        100  health removed per accepted hit
//  INVULN_FRAMES 60   frames of invincibility after an accepted hit (1..255)
//  KO_FRAMES     180  frames held in KO state before returning to IDLE (1..1023)
//  REGEN_FRAMES  30   frames per +1 health regen step (HEALTH_REGEN_EN only)
// PORTS
//  clk         in   1                        system clock
//  rst         in   1                        synchronous, active-high reset
//  frame_tick  in   1                        1-cycle pulse per video frame (from v_sync falling edge)
//  start       in   1                        begin round (level, sampled in IDLE)
//  hit         in   NUM_PLAYERS              bit i: player i struck this cycle (level)
//  health      out  NUM_PLAYERS*HEALTH_W     flat bus, player i at [i*HEALTH_W +: HEALTH_W]
//  invincible  out  NUM_PLAYERS              bit i: player i currently ignores hits
//  hit_ack     out  NUM_PLAYERS              1-cycle pulse: hit on player i accepted
//  state       out  2                        0=IDLE 1=FIGHT 2=KO
//  winner      out  NUM_PLAYERS              one-hot survivor; all-zero = draw or no result
//  game_over   out  1                        high while state==KO
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge clk): state=IDLE, health[i]=MAX_HEALTH, invincible=0, hit_ack=0,
//   winner=0, game_over=0, all counters 0. Reset mid-round aborts immediately, no KO reported.
//  IDLE: hits ignored. start=1 -> FIGHT next cycle; health reloaded to MAX_HEALTH, invincibility cleared, winner=0.
//  FIGHT, per player i, evaluated same cycle for all players:
//   - hit[i]=1 and invincible[i]=0 and health[i]>0 -> accepted: hit_ack[i]=1 for one cycle;
//     health[i] <= (health[i] > DAMAGE) ? health[i]-DAMAGE : 0 (saturating, never wraps);
//     invuln counter[i] <= INVULN_FRAMES, invincible[i]=1 from the next cycle.
//   - hit held high across cycles counts once: invincibility blocks repeats; hit=1 with invincible=1 -> no ack, no change.
//   - counter[i] decrements on frame_tick while >0; invincible[i] = (counter[i]!=0). Accepted hit on same cycle as
//     frame_tick reloads (reload wins over decrement).
//  KO detect: registered, one cycle after the health update. When >=1 player's health==0 -> KO.
//   Exactly one survivor with health>0 -> winner one-hot to it. All at 0 (simultaneous final hits) -> winner=0 (draw).
//   More than one survivor (NUM_PLAYERS>2) -> stay in FIGHT; eliminated players take no further hits.
//  KO: game_over=1, hits ignored, health frozen, ko counter counts frame_tick; after KO_FRAMES ticks -> IDLE,
//   game_over=0; winner and health held until next start.
//  Latency: hit -> hit_ack/health 1 cycle; hit -> state KO 2 cycles.
//  Outputs all registered; no combinational path input->output.
// CONFIGURATION
//  HEALTH_REGEN_EN defined: in FIGHT, player with 0<health<MAX_HEALTH and invincible=0 gains +1 every
//   REGEN_FRAMES frame_ticks (per-player counter, restarts on accepted hit); saturates at MAX_HEALTH.
//   Regen and accepted hit same cycle -> hit applied, regen dropped.
//  Not defined: no regen logic or counters; health only decreases during a round.
// TESTING
//  T1 reset: rst=1 2 cycles -> state=0, every health=300, invincible=0, winner=0, game_over=0.
//  T2 single hit: start, hit[0]=1 one cycle -> hit_ack[0] pulse, health0=200, invincible[0]=1 for exactly 60 frame_ticks.
//  T3 hold/blocked: hit[0] high 100 cycles, no frame_tick -> one ack only, health0=200.
//  T4 KO: 3 spaced hits on player 1 -> health1=0, 2 cycles later state=2, winner=2'b01, game_over=1;
//     after 180 frame_ticks state=0, game_over=0.
//  T5 draw: both at 100, hit=2'b11 same cycle -> both 0, state=2, winner=0.
//  T6 mid-round reset + regen (HEALTH_REGEN_EN): health0=200, 30 ticks after invuln ends -> 201; rst -> 300, IDLE.

Source files
------------

// File: rtl/combat_arbiter.sv
// combat_arbiter
//   Hit / health / round controller for the VGA fighting game. Accepts
//   per-player hit requests from the collision logic, applies damage,
//   runs frame-based invincibility, and detects KO or draw. All state
//   changes happen on clk. Invincibility, KO and regen timing count
//   frame_tick pulses.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous, active-high reset
//   frame_tick  in   one-cycle pulse per video frame
//   start       in   begin a round (level, sampled in IDLE)
//   hit         in   [NUM_PLAYERS]  bit i: player i struck this cycle
//   health      out  [NUM_PLAYERS*HEALTH_W]  player i at [i*HEALTH_W +: HEALTH_W]
//   invincible  out  [NUM_PLAYERS]  player i currently ignores hits
//   hit_ack     out  [NUM_PLAYERS]  one-cycle pulse: hit on player i accepted
//   state       out  [2]            0=IDLE 1=FIGHT 2=KO
//   winner      out  [NUM_PLAYERS]  one-hot survivor, zero = draw / no result
//   game_over   out  high while in KO
//
// Optional feature
//   HEALTH_REGEN_EN  when defined, a living, non-invincible player below
//                    MAX_HEALTH gains +1 health every REGEN_FRAMES frame ticks.
//                    When undefined, health only decreases during a round.
module combat_arbiter #(
    parameter int NUM_PLAYERS   = 2,
    parameter int HEALTH_W      = 11,
    parameter int MAX_HEALTH    = 300,
    parameter int DAMAGE        = 100,
    parameter int INVULN_FRAMES = 60,
    parameter int KO_FRAMES     = 180,
    parameter int REGEN_FRAMES  = 30
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            frame_tick,
    input  logic                            start,
    input  logic [NUM_PLAYERS-1:0]          hit,
    output logic [NUM_PLAYERS*HEALTH_W-1:0] health,
    output logic [NUM_PLAYERS-1:0]          invincible,
    output logic [NUM_PLAYERS-1:0]          hit_ack,
    output logic [1:0]                      state,
    output logic [NUM_PLAYERS-1:0]          winner,
    output logic                            game_over
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIGHT = 2'd1,
        KO    = 2'd2
    } state_t;

    localparam logic [HEALTH_W-1:0] FULL        = HEALTH_W'(MAX_HEALTH);
    localparam logic [HEALTH_W-1:0] DMG         = HEALTH_W'(DAMAGE);
    localparam logic [7:0]          INVULN_LOAD = 8'(INVULN_FRAMES);
    localparam logic [9:0]          KO_LAST     = 10'(KO_FRAMES - 1);

    // Reject parameter sets that would not fit the counters or health width.
    if (NUM_PLAYERS < 2 || MAX_HEALTH >= (1 << HEALTH_W) ||
        INVULN_FRAMES < 1 || INVULN_FRAMES > 255 ||
        KO_FRAMES < 1 || KO_FRAMES > 1023 || REGEN_FRAMES < 1) begin : g_bad_cfg
        $error("combat_arbiter: illegal parameter combination");
    end

    state_t                 cur_state;
    logic [HEALTH_W-1:0]    hp      [NUM_PLAYERS];
    logic [7:0]             inv_cnt [NUM_PLAYERS];
    logic [9:0]             ko_cnt;
    logic [NUM_PLAYERS-1:0] alive;
    logic [NUM_PLAYERS-1:0] accept;
    logic                   ko_now;

`ifdef HEALTH_REGEN_EN
    localparam logic [15:0] RG_LAST = 16'(REGEN_FRAMES - 1);
    logic [15:0] rg_cnt [NUM_PLAYERS];
`endif

    always_comb begin
        alive = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            alive[i] = (hp[i] != '0);
        end
    end

    // The round ends once somebody is out and at most one player still
    // stands. The alive-mask trick (x & (x-1)) == 0 means "zero or one bit
    // set".
    assign ko_now = (cur_state == FIGHT) &&
                    (alive != {NUM_PLAYERS{1'b1}}) &&
                    ((alive & (alive - NUM_PLAYERS'(1))) == '0);

    // Hits are also refused in the cycle the KO is being decided. The
    // registered winner then always matches the frozen health values.
    always_comb begin
        accept = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            accept[i] = (cur_state == FIGHT) && !ko_now && hit[i] &&
                        (inv_cnt[i] == 8'd0) && alive[i];
        end
    end

    always_comb begin
        health     = '0;
        invincible = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            health[i*HEALTH_W +: HEALTH_W] = hp[i];
            invincible[i]                  = (inv_cnt[i] != 8'd0);
        end
    end

    assign state = cur_state;

    // Round FSM plus per-player health and timers. The invulnerability
    // counters run down on frame_tick in every state. An accepted hit
    // reloads the counter and wins over a same-cycle decrement. Starting a
    // round clears the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= IDLE;
            hit_ack   <= '0;
            winner    <= '0;
            game_over <= 1'b0;
            ko_cnt    <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                hp[i]      <= FULL;
                inv_cnt[i] <= '0;
`ifdef HEALTH_REGEN_EN
                rg_cnt[i]  <= '0;
`endif
            end
        end else begin
            hit_ack <= accept;

            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (accept[i]) begin
                    inv_cnt[i] <= INVULN_LOAD;
                end else if (frame_tick && inv_cnt[i] != 8'd0) begin
                    inv_cnt[i] <= inv_cnt[i] - 8'd1;
                end
            end

            case (cur_state)
                IDLE: begin
                    if (start) begin
                        cur_state <= FIGHT;
                        winner    <= '0;
                        for (int i = 0; i < NUM_PLAYERS; i++) begin
                            hp[i]      <= FULL;
                            inv_cnt[i] <= '0;
`ifdef HEALTH_REGEN_EN
                            rg_cnt[i]  <= '0;
`endif
                        end
                    end
                end

                FIGHT: begin
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        if (accept[i]) begin
                            hp[i] <= (hp[i] > DMG) ? (hp[i] - DMG) : '0;
`ifdef HEALTH_REGEN_EN
                            rg_cnt[i] <= '0;
`endif
                        end
`ifdef HEALTH_REGEN_EN
                        // The regen count only advances while the player
                        // is eligible. Any ineligible cycle restarts it.
                        else if (!ko_now && alive[i] && hp[i] < FULL &&
                                 inv_cnt[i] == 8'd0) begin
                            if (frame_tick) begin
                                if (rg_cnt[i] == RG_LAST) begin
                                    hp[i]     <= hp[i] + HEALTH_W'(1);
                                    rg_cnt[i] <= '0;
                                end else begin
                                    rg_cnt[i] <= rg_cnt[i] + 16'd1;
                                end
                            end
                        end else begin
                            rg_cnt[i] <= '0;
                        end
`endif
                    end
                    if (ko_now) begin
                        cur_state <= KO;
                        winner    <= alive;
                        game_over <= 1'b1;
                        ko_cnt    <= '0;
                    end
                end

                KO: begin
                    if (frame_tick) begin
                        if (ko_cnt == KO_LAST) begin
                            cur_state <= IDLE;
                            game_over <= 1'b0;
                            ko_cnt    <= '0;
                        end else begin
                            ko_cnt <= ko_cnt + 10'd1;
                        end
                    end
                end

                default: begin
                    cur_state <= IDLE;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_combat_arbiter.sv
// Testbench for combat_arbiter: directed scenarios plus a randomized run
// checked against a round-level behavioural model.
module tb_combat_arbiter;

    localparam int NP   = 2;
    localparam int HW   = 11;
    localparam int MAXH = 300;
    localparam int DMG  = 100;
    localparam int INV  = 60;
    localparam int KOF  = 180;
`ifdef HEALTH_REGEN_EN
    localparam int RGF  = 30;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_tick;
    logic              start;
    logic [NP-1:0]     hit;
    logic [NP*HW-1:0]  health;
    logic [NP-1:0]     invincible;
    logic [NP-1:0]     hit_ack;
    logic [1:0]        state;
    logic [NP-1:0]     winner;
    logic              game_over;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: round phase, health, frames of protection left.
    int            m_state;
    int            m_hp  [NP];
    int            m_inv [NP];
    logic [NP-1:0] m_ack;
    logic [NP-1:0] m_win;
    int            m_ko;
`ifdef HEALTH_REGEN_EN
    int            m_rg  [NP];
`endif

    combat_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .start      (start),
        .hit        (hit),
        .health     (health),
        .invincible (invincible),
        .hit_ack    (hit_ack),
        .state      (state),
        .winner     (winner),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock given the inputs seen at that edge.
    task automatic model_step(input bit r, input bit st, input bit [NP-1:0] h, input bit ft);
        int  alive_n;
        int  last_alive;
        bit  decide;
        bit  acc;
        if (r) begin
            m_state = 0;
            m_ack   = '0;
            m_win   = '0;
            m_ko    = 0;
            for (int i = 0; i < NP; i++) begin
                m_hp[i]  = MAXH;
                m_inv[i] = 0;
`ifdef HEALTH_REGEN_EN
                m_rg[i]  = 0;
`endif
            end
            return;
        end
        alive_n    = 0;
        last_alive = 0;
        for (int i = 0; i < NP; i++) begin
            if (m_hp[i] > 0) begin
                alive_n++;
                last_alive = i;
            end
        end
        m_ack = '0;
        if (m_state == 1) begin
            decide = (alive_n < NP) && (alive_n <= 1);
            for (int i = 0; i < NP; i++) begin
                acc = !decide && h[i] && m_inv[i] == 0 && m_hp[i] > 0;
                if (acc) begin
                    m_ack[i] = 1'b1;
                    m_hp[i]  = (m_hp[i] > DMG) ? m_hp[i] - DMG : 0;
                    m_inv[i] = INV;
`ifdef HEALTH_REGEN_EN
                    m_rg[i]  = 0;
`endif
                end else begin
`ifdef HEALTH_REGEN_EN
                    if (!decide && m_hp[i] > 0 && m_hp[i] < MAXH && m_inv[i] == 0) begin
                        if (ft) begin
                            m_rg[i]++;
                            if (m_rg[i] == RGF) begin
                                m_hp[i]++;
                                m_rg[i] = 0;
                            end
                        end
                    end else begin
                        m_rg[i] = 0;
                    end
`endif
                    if (ft && m_inv[i] > 0) m_inv[i]--;
                end
            end
            if (decide) begin
                m_state = 2;
                m_win   = (alive_n == 1) ? NP'(1 << last_alive) : '0;
                m_ko    = 0;
            end
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (ft && m_inv[i] > 0) m_inv[i]--;
            end
            if (m_state == 0) begin
                if (st) begin
                    m_state = 1;
                    m_win   = '0;
                    for (int i = 0; i < NP; i++) begin
                        m_hp[i]  = MAXH;
                        m_inv[i] = 0;
`ifdef HEALTH_REGEN_EN
                        m_rg[i]  = 0;
`endif
                    end
                end
            end else if (ft) begin
                m_ko++;
                if (m_ko == KOF) m_state = 0;
            end
        end
    endtask

    // Drive one clock of inputs, update the model, then settle past the edge.
    task automatic cycle(input bit r, input bit st, input bit [NP-1:0] h, input bit ft);
        rst        = r;
        start      = st;
        hit        = h;
        frame_tick = ft;
        @(posedge clk);
        model_step(r, st, h, ft);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic new_round();
        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b1, '0, 1'b0);
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (state !== 2'd0) begin
            failures++; $display("[TB] FAIL reset_state got=%0d exp=0", state);
        end
        checks++;
        if (health !== {11'd300, 11'd300}) begin
            failures++; $display("[TB] FAIL reset_health got=%h exp=%h", health, {11'd300, 11'd300});
        end
        checks++;
        if (invincible !== 2'b00 || hit_ack !== 2'b00) begin
            failures++; $display("[TB] FAIL reset_inv_ack got=%b/%b exp=00/00", invincible, hit_ack);
        end
        checks++;
        if (winner !== 2'b00 || game_over !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_result got=%b/%b exp=00/0", winner, game_over);
        end
        // Hits in IDLE are ignored.
        cycle(1'b0, 1'b0, 2'b11, 1'b0);
        checks++;
        if (hit_ack !== 2'b00 || health !== {11'd300, 11'd300}) begin
            failures++; $display("[TB] FAIL idle_hit_ignored ack=%b health=%h exp=00/%h", hit_ack, health, {11'd300, 11'd300});
        end
    endtask

    task automatic test_single_hit();
        int bad;
        new_round();
        checks++;
        if (state !== 2'd1) begin
            failures++; $display("[TB] FAIL start_state got=%0d exp=1", state);
        end
        cycle(1'b0, 1'b0, 2'b01, 1'b0);
        checks++;
        if (hit_ack !== 2'b01 || health[0 +: HW] !== 11'd200 || health[HW +: HW] !== 11'd300) begin
            failures++; $display("[TB] FAIL single_hit ack=%b h0=%0d h1=%0d exp=01/200/300", hit_ack, health[0 +: HW], health[HW +: HW]);
        end
        checks++;
        if (invincible !== 2'b01) begin
            failures++; $display("[TB] FAIL inv_set got=%b exp=01", invincible);
        end
        cycle(1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (hit_ack !== 2'b00) begin
            failures++; $display("[TB] FAIL ack_pulse got=%b exp=00", hit_ack);
        end
        bad = 0;
        for (int k = 0; k < INV - 1; k++) begin
            ticks(1);
            if (invincible !== 2'b01) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("[TB] FAIL inv_held cycles_dropped=%0d exp=0", bad);
        end
        ticks(1);
        checks++;
        if (invincible !== 2'b00) begin
            failures++; $display("[TB] FAIL inv_expire got=%b exp=00", invincible);
        end
    endtask

    task automatic test_hold_blocked();
        int acks;
        new_round();
        acks = 0;
        for (int k = 0; k < 100; k++) begin
            cycle(1'b0, 1'b0, 2'b01, 1'b0);
            if (hit_ack[0] === 1'b1) acks++;
        end
        checks++;
        if (acks != 1) begin
            failures++; $display("[TB] FAIL hold_ack_count got=%0d exp=1", acks);
        end
        checks++;
        if (health[0 +: HW] !== 11'd200) begin
            failures++; $display("[TB] FAIL hold_health got=%0d exp=200", health[0 +: HW]);
        end
    endtask

    task automatic test_ko();
        new_round();
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 2'b10, 1'b0);
            if (k < 2) ticks(INV);
        end
        checks++;
        if (health[HW +: HW] !== 11'd0 || hit_ack !== 2'b10 || state !== 2'd1) begin
            failures++; $display("[TB] FAIL ko_final_hit h1=%0d ack=%b state=%0d exp=0/10/1", health[HW +: HW], hit_ack, state);
        end
        cycle(1'b0, 1'b0, 2'b01, 1'b0);
        checks++;
        if (state !== 2'd2 || winner !== 2'b01 || game_over !== 1'b1) begin
            failures++; $display("[TB] FAIL ko_enter state=%0d win=%b go=%b exp=2/01/1", state, winner, game_over);
        end
        checks++;
        if (health[0 +: HW] !== 11'd300 || hit_ack !== 2'b00) begin
            failures++; $display("[TB] FAIL ko_decide_hit h0=%0d ack=%b exp=300/00", health[0 +: HW], hit_ack);
        end
        ticks(KOF - 1);
        cycle(1'b0, 1'b0, 2'b01, 1'b0);
        checks++;
        if (state !== 2'd2 || game_over !== 1'b1 || health[0 +: HW] !== 11'd300) begin
            failures++; $display("[TB] FAIL ko_hold state=%0d go=%b h0=%0d exp=2/1/300", state, game_over, health[0 +: HW]);
        end
        ticks(1);
        checks++;
        if (state !== 2'd0 || game_over !== 1'b0 || winner !== 2'b01) begin
            failures++; $display("[TB] FAIL ko_exit state=%0d go=%b win=%b exp=0/0/01", state, game_over, winner);
        end
        checks++;
        if (health[HW +: HW] !== 11'd0) begin
            failures++; $display("[TB] FAIL ko_health_held h1=%0d exp=0", health[HW +: HW]);
        end
    endtask

    task automatic test_draw();
        new_round();
        cycle(1'b0, 1'b0, 2'b11, 1'b0);
        ticks(INV);
        cycle(1'b0, 1'b0, 2'b11, 1'b0);
        ticks(INV);
        checks++;
        if (health !== {11'd100, 11'd100}) begin
            failures++; $display("[TB] FAIL draw_pre got=%h exp=%h", health, {11'd100, 11'd100});
        end
        cycle(1'b0, 1'b0, 2'b11, 1'b0);
        checks++;
        if (health !== '0 || hit_ack !== 2'b11) begin
            failures++; $display("[TB] FAIL draw_final health=%h ack=%b exp=0/11", health, hit_ack);
        end
        cycle(1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (state !== 2'd2 || winner !== 2'b00 || game_over !== 1'b1) begin
            failures++; $display("[TB] FAIL draw_result state=%0d win=%b go=%b exp=2/00/1", state, winner, game_over);
        end
    endtask

    task automatic test_mid_round_reset();
        new_round();
        cycle(1'b0, 1'b0, 2'b01, 1'b0);
`ifdef HEALTH_REGEN_EN
        ticks(INV);
        ticks(RGF - 1);
        checks++;
        if (health[0 +: HW] !== 11'd200) begin
            failures++; $display("[TB] FAIL regen_early got=%0d exp=200", health[0 +: HW]);
        end
        ticks(1);
        checks++;
        if (health[0 +: HW] !== 11'd201) begin
            failures++; $display("[TB] FAIL regen_step got=%0d exp=201", health[0 +: HW]);
        end
`endif
        cycle(1'b1, 1'b0, 2'b10, 1'b0);
        checks++;
        if (state !== 2'd0 || health !== {11'd300, 11'd300} || invincible !== 2'b00 || hit_ack !== 2'b00) begin
            failures++; $display("[TB] FAIL mid_reset state=%0d health=%h inv=%b ack=%b", state, health, invincible, hit_ack);
        end
        // A reset landing on the KO-decision cycle aborts without a result.
        new_round();
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 2'b10, 1'b0);
            if (k < 2) ticks(INV);
        end
        cycle(1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (state !== 2'd0 || winner !== 2'b00 || game_over !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_abort_ko state=%0d win=%b go=%b exp=0/00/0", state, winner, game_over);
        end
    endtask

    task automatic test_random();
        bit            r;
        bit            st;
        bit [NP-1:0]   h;
        bit            ft;
        logic [NP*HW-1:0] exp_health;
        logic [NP-1:0]    exp_inv;
        int            errs;
        cycle(1'b1, 1'b0, '0, 1'b0);
        errs = 0;
        for (int n = 0; n < 6000; n++) begin
            r  = ($urandom_range(0, 799) == 0);
            st = ($urandom_range(0, 7) == 0);
            h  = ($urandom_range(0, 4) == 0) ? NP'($urandom) : '0;
            ft = ($urandom_range(0, 2) == 0);
            cycle(r, st, h, ft);
            exp_health = '0;
            exp_inv    = '0;
            for (int i = 0; i < NP; i++) begin
                exp_health[i*HW +: HW] = HW'(m_hp[i]);
                exp_inv[i]             = (m_inv[i] != 0);
            end
            checks++;
            if (state !== 2'(m_state) || game_over !== (m_state == 2)) begin
                failures++; errs++;
                if (errs < 10) $display("[TB] FAIL rand_state cyc=%0d got=%0d/%b exp=%0d", n, state, game_over, m_state);
            end
            checks++;
            if (health !== exp_health) begin
                failures++; errs++;
                if (errs < 10) $display("[TB] FAIL rand_health cyc=%0d got=%h exp=%h", n, health, exp_health);
            end
            checks++;
            if (invincible !== exp_inv || hit_ack !== m_ack || winner !== m_win) begin
                failures++; errs++;
                if (errs < 10) $display("[TB] FAIL rand_flags cyc=%0d inv=%b/%b ack=%b/%b win=%b/%b", n, invincible, exp_inv, hit_ack, m_ack, winner, m_win);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        hit        = '0;
        frame_tick = 1'b0;
        test_reset();
        test_single_hit();
        test_hold_blocked();
        test_ko();
        test_draw();
        test_mid_round_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
